// File: rtl/lenet_dma_pkg.sv
// Shared definitions for the LeNet DMA engines (write-back and loader):
// state encodings, DMA size code, beat width and default transfer geometry.
package lenet_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CTRL   = 2'd1,
        ST_DATA   = 2'd2,
        ST_FINISH = 2'd3
    } dma_state_e;

    localparam logic [2:0] DMA_SIZE_WORD    = 3'b010;
    localparam int         WORD_W           = 32;
    localparam int         BEAT_W           = 64;
    localparam int         DEF_WRITE_INDEX  = 10000;
    localparam int         DEF_WRITE_LENGTH = 5;

    // Two SRAM words form one beat; the odd-addressed word is the upper half.
    function automatic logic [BEAT_W-1:0] pack_beat(input logic [WORD_W-1:0] hi_word,
                                                    input logic [WORD_W-1:0] lo_word);
        return {hi_word, lo_word};
    endfunction

endpackage

// File: rtl/dma_beat_skid.sv
// One-entry 64-bit skid register in front of a valid/ready output register.
// The producer must never present data while both entries are occupied.
module dma_beat_skid
    import lenet_dma_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n_i,
    input  logic              in_valid_i,
    input  logic [BEAT_W-1:0] in_data_i,
    output logic              skid_valid_o,
    input  logic              out_ready_i,
    output logic              out_valid_o,
    output logic [BEAT_W-1:0] out_data_o
);

    logic              out_valid_q, out_valid_d;
    logic [BEAT_W-1:0] out_data_q,  out_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [BEAT_W-1:0] skid_data_q,  skid_data_d;
    logic              out_free;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        out_free     = !out_valid_q || out_ready_i;

        if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = in_valid_i;
                if (in_valid_i) begin
                    skid_data_d = in_data_i;
                end
            end else begin
                // Arriving data bypasses the skid whenever the output slot frees up.
                out_valid_d = in_valid_i;
                if (in_valid_i) begin
                    out_data_d = in_data_i;
                end
            end
        end else if (in_valid_i) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data_i;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so all registers sample pre-edge values.
        if (!rst_n_i) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign skid_valid_o = skid_valid_q;
    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;

endmodule

// File: rtl/lenet_dma_writeback.sv
// Write-back engine: issues one DMA write control request, then streams
// WRITE_LENGTH 64-bit beats packed from pairs of activation SRAM words.
module lenet_dma_writeback
    import lenet_dma_pkg::*;
#(
    parameter int WRITE_INDEX  = DEF_WRITE_INDEX,
    parameter int WRITE_LENGTH = DEF_WRITE_LENGTH,
    parameter int SRAM_BASE    = 0,
    parameter int ADDR_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              done,
    output logic [ADDR_W-1:0] sram_addr0,
    output logic [ADDR_W-1:0] sram_addr1,
    input  logic [WORD_W-1:0] sram_rdata0,
    input  logic [WORD_W-1:0] sram_rdata1,
    input  logic              dma_write_ctrl_ready,
    output logic              dma_write_ctrl_valid,
    output logic [31:0]       dma_write_ctrl_data_index,
    output logic [31:0]       dma_write_ctrl_data_length,
    output logic [2:0]        dma_write_ctrl_data_size,
    input  logic              dma_write_chnl_ready,
    output logic              dma_write_chnl_valid,
    output logic [BEAT_W-1:0] dma_write_chnl_data
);

    if (WRITE_LENGTH < 1) begin : g_length_check
        $error("lenet_dma_writeback: WRITE_LENGTH must be at least 1");
    end

    localparam logic [31:0]       LEN       = 32'(WRITE_LENGTH);
    localparam logic [31:0]       LAST_BEAT = 32'(WRITE_LENGTH - 1);
    localparam logic [ADDR_W-1:0] BASE0     = ADDR_W'(SRAM_BASE);
    localparam logic [ADDR_W-1:0] BASE1     = ADDR_W'(SRAM_BASE + 1);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(2);

    dma_state_e        state_q, state_d;
    logic              ctrl_valid_q, ctrl_valid_d;
    logic [31:0]       ctrl_index_q, ctrl_index_d;
    logic [31:0]       ctrl_length_q, ctrl_length_d;
    logic [2:0]        ctrl_size_q, ctrl_size_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] addr0_q, addr0_d;
    logic [ADDR_W-1:0] addr1_q, addr1_d;
    logic [31:0]       issue_cnt_q, issue_cnt_d;
    logic [31:0]       sent_cnt_q, sent_cnt_d;
    logic              rd_pend_q, rd_pend_d;

    logic              chnl_valid;
    logic [BEAT_W-1:0] chnl_data;
    logic              skid_valid;
    logic              chnl_hs;
    logic              ctrl_hs;
    logic [1:0]        occupancy;
    logic              issue;

    assign chnl_hs = chnl_valid & dma_write_chnl_ready;
    assign ctrl_hs = ctrl_valid_q & dma_write_ctrl_ready;

    // Beats already committed to the two storage slots, net of the one leaving now.
    assign occupancy = 2'(rd_pend_q) + 2'(skid_valid) + 2'(chnl_valid) - 2'(chnl_hs);
    assign issue     = (state_q == ST_DATA) && (issue_cnt_q < LEN) && (occupancy < 2'd2);

    always_comb begin
        state_d       = state_q;
        ctrl_valid_d  = ctrl_valid_q;
        ctrl_index_d  = ctrl_index_q;
        ctrl_length_d = ctrl_length_q;
        ctrl_size_d   = ctrl_size_q;
        done_d        = 1'b0;
        addr0_d       = addr0_q;
        addr1_d       = addr1_q;
        issue_cnt_d   = issue_cnt_q;
        sent_cnt_d    = sent_cnt_q;
        rd_pend_d     = issue;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_CTRL;
                    ctrl_valid_d  = 1'b1;
                    ctrl_index_d  = 32'(WRITE_INDEX);
                    ctrl_length_d = LEN;
                    ctrl_size_d   = DMA_SIZE_WORD;
                    addr0_d       = BASE0;
                    addr1_d       = BASE1;
                    issue_cnt_d   = '0;
                    sent_cnt_d    = '0;
                end
            end
            ST_CTRL: begin
                if (ctrl_hs) begin
                    state_d       = ST_DATA;
                    ctrl_valid_d  = 1'b0;
                    ctrl_index_d  = '0;
                    ctrl_length_d = '0;
                    ctrl_size_d   = '0;
                end
            end
            ST_DATA: begin
                if (issue) begin
                    issue_cnt_d = issue_cnt_q + 32'd1;
                    // The address stays on the final pair once the last read is out.
                    if (issue_cnt_q < LAST_BEAT) begin
                        addr0_d = addr0_q + ADDR_STEP;
                        addr1_d = addr1_q + ADDR_STEP;
                    end
                end
                if (chnl_hs) begin
                    sent_cnt_d = sent_cnt_q + 32'd1;
                    if (sent_cnt_q == LAST_BEAT) begin
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            ctrl_valid_q  <= 1'b0;
            ctrl_index_q  <= '0;
            ctrl_length_q <= '0;
            ctrl_size_q   <= '0;
            done_q        <= 1'b0;
            addr0_q       <= '0;
            addr1_q       <= '0;
            issue_cnt_q   <= '0;
            sent_cnt_q    <= '0;
            rd_pend_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ctrl_valid_q  <= ctrl_valid_d;
            ctrl_index_q  <= ctrl_index_d;
            ctrl_length_q <= ctrl_length_d;
            ctrl_size_q   <= ctrl_size_d;
            done_q        <= done_d;
            addr0_q       <= addr0_d;
            addr1_q       <= addr1_d;
            issue_cnt_q   <= issue_cnt_d;
            sent_cnt_q    <= sent_cnt_d;
            rd_pend_q     <= rd_pend_d;
        end
    end

    // SRAM data is valid the cycle after its read issued, tracked by rd_pend_q.
    dma_beat_skid u_skid (
        .clk          (clk),
        .rst_n_i      (rst),
        .in_valid_i   (rd_pend_q),
        .in_data_i    (pack_beat(sram_rdata1, sram_rdata0)),
        .skid_valid_o (skid_valid),
        .out_ready_i  (dma_write_chnl_ready),
        .out_valid_o  (chnl_valid),
        .out_data_o   (chnl_data)
    );

    assign done                       = done_q;
    assign sram_addr0                 = addr0_q;
    assign sram_addr1                 = addr1_q;
    assign dma_write_ctrl_valid       = ctrl_valid_q;
    assign dma_write_ctrl_data_index  = ctrl_index_q;
    assign dma_write_ctrl_data_length = ctrl_length_q;
    assign dma_write_ctrl_data_size   = ctrl_size_q;
    assign dma_write_chnl_valid       = chnl_valid;
    assign dma_write_chnl_data        = chnl_data;

endmodule

// File: doc/lenet_dma_writeback.md
Name: lenet_dma_writeback

Overview:
Write-back engine for the LeNet accelerator: the transmit-side counterpart of the weight/activation DMA loader.
- On start, reads result words from the activation SRAM over both 32-bit read ports and packs them into 64-bit beats.
- Issues one DMA write control request, then streams the beats over dma_write_chnl with full backpressure support.
- Sits between the top-level FSM (WRITE state) and the ESP-style DMA write interface; pulses done when the last beat is accepted.

Parameters:
- WRITE_INDEX, 10000: dma_write_ctrl_data_index value (word offset in memory).
- WRITE_LENGTH, 5: beats to transfer; also driven on dma_write_ctrl_data_length; elaboration error if < 1.
- SRAM_BASE, 0: first activation SRAM word address read.
- ADDR_W, 16: SRAM address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- start  in  1  one-cycle request from top FSM; ignored unless IDLE
- done  out  1  one-cycle pulse after last beat handshake
- sram_addr0  out  ADDR_W  activation SRAM port-0 read address
- sram_addr1  out  ADDR_W  activation SRAM port-1 read address
- sram_rdata0  in  32  port-0 read data, 1-cycle latency
- sram_rdata1  in  32  port-1 read data, 1-cycle latency
- dma_write_ctrl_ready  in  1  DMA accepts control
- dma_write_ctrl_valid  out  1  control request valid
- dma_write_ctrl_data_index  out  32  WRITE_INDEX
- dma_write_ctrl_data_length  out  32  WRITE_LENGTH
- dma_write_ctrl_data_size  out  3  fixed 3'b010
- dma_write_chnl_ready  in  1  DMA accepts data beat
- dma_write_chnl_valid  out  1  data beat valid
- dma_write_chnl_data  out  64  {word 2i+1, word 2i}

Behaviour:
- Single clock domain. Reset is synchronous and active-low on rst.
- Every output and internal register resets to 0. State resets to IDLE.
- States:
  - IDLE -> CTRL on start.
  - CTRL: ctrl_valid=1 with index, length and size held stable. Goes to DATA on a cycle with ctrl_valid and ctrl_ready both high.
  - DATA -> FINISH on the handshake of beat WRITE_LENGTH-1.
  - FINISH: done=1 for exactly one cycle, then IDLE.
- The ctrl_* data outputs are 0 outside CTRL.
- ctrl_valid never drops before its handshake.
- Beat i reads sram_addr0=SRAM_BASE+2i and sram_addr1=SRAM_BASE+2i+1. Data is {sram_rdata1, sram_rdata0}.
- Addresses are registered outputs; an SRAM read issued in cycle t returns data in cycle t+1.
- Datapath:
  - Issue stage, then the SRAM, then an optional 1-entry skid register, then the output register (chnl_valid/chnl_data).
  - occupancy = reads in flight + skid_valid + chnl_valid.
  - A read issues when beats remain to issue and (occupancy − handshake_this_cycle) < 2.
  - Returning SRAM data goes to the output register if it is free or being handshaked; otherwise it goes to the skid. It is never dropped.
- AXI-style rules: chnl_valid and chnl_data stay stable until chnl_ready. The block never deasserts valid without a handshake.
- chnl_valid is never asserted outside DATA.
- Latency: first chnl_valid is asserted 3 cycles after the ctrl handshake cycle.
- Throughput: with chnl_ready held high, 1 beat/cycle sustained.
- Counters: issue_cnt and sent_cnt are 32-bit, compared against WRITE_LENGTH. No reads issue beyond the last beat.
- start during CTRL, DATA or FINISH is ignored.
- rst low mid-transfer: next cycle all outputs are 0 and state is IDLE. No done pulse; the partial transfer is abandoned.
- Simultaneous arrival of SRAM data and a handshake on the last in-register beat: the new data loads the output register directly and the skid stays empty.

Decomposition:
- Shared package lenet_dma_pkg:
  - state encodings (shared with the read engine);
  - DMA_SIZE_WORD = 3'b010;
  - BEAT_W = 64;
  - default WRITE_INDEX and WRITE_LENGTH constants.
- One sub-module, dma_beat_skid: a 1-entry, 64-bit valid/ready skid buffer plus output register.
  - Reused later for the read path's SRAM-backpressure case.

Test Plan:
- Reset then start, with ctrl_ready high at the first CTRL cycle and chnl_ready always 1; SRAM preloaded with word k = k.
  - One ctrl handshake with index 10000, length 5, size 3'b010.
  - Beats {1,0}, {3,2} … {9,8} on 5 consecutive cycles, the first 3 cycles after the ctrl handshake.
  - done pulses once, in the cycle after the last beat's handshake.
- ctrl_ready held low for 4 cycles: ctrl_valid and its data stay stable for all 4 cycles, and no SRAM address advances.
- chnl_ready toggled 1,0,0,1,0,1…: each beat is held stable while ready is low, there are no duplicates or drops, and order is beats 0..4.
- chnl_ready low for 10 cycles mid-stream: at most 2 reads are outstanding/buffered, and the remaining beats are delivered intact after ready rises.
- rst low during beat 2: all outputs are 0 the next cycle and there is no done. A new start gives a clean transfer beginning at beat 0.
- start pulsed during DATA: ignored, so there is no second ctrl request and exactly 5 beats are sent.
